// File: rtl/fmap_streamer_if.sv
// Feature-RAM read port and outgoing pixel stream of fmap_streamer.
// The master side is the streamer; the slave side is the RAM plus the first conv layer.
interface fmap_streamer_if #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 16
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] stream_dout;
  logic              stream_vld;
  logic              stream_end;

  modport master (
    output mem_rd, mem_addr, stream_dout, stream_vld, stream_end,
    input  mem_dout
  );

  modport slave (
    input  mem_rd, mem_addr, stream_dout, stream_vld, stream_end,
    output mem_dout
  );
endinterface

// File: rtl/fmap_streamer.sv
// Frame source: reads one SIZE x SIZE feature map in raster order and emits it as a vld/din/end pixel stream.
// Optional macro FMAP_STREAM_GAP_EN inserts ROW_GAP idle cycles between rows.
module fmap_streamer #(
  parameter int N         = 16,
  parameter int CHANNEL   = 3,
  parameter int SIZE      = 6,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0,
  parameter int ROW_GAP   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic start,
  output logic busy,
  output logic done,
  fmap_streamer_if.master bus
);
  localparam int DW    = CHANNEL * N;
  localparam int CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SIZE - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, GAP = 2'd2, LAST = 2'd3} state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  row_r, row_s, col_r, col_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic              rd_r, rd_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              vld_r, end_r;
  logic [DW-1:0]     hold_r;
  logic              last_pix_s;

`ifdef FMAP_STREAM_GAP_EN
  localparam int GAP_W = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((ROW_GAP > 0) ? (ROW_GAP - 1) : 0);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  logic [GAP_W-1:0] gap_r, gap_s;
`else
  localparam int unused_row_gap = ROW_GAP;
`endif

  assign last_pix_s = (row_r == CNT_LAST) && (col_r == CNT_LAST);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else if (ce) begin
      state_r <= state_s;
    end
  end

  // Next-state, read sequencing and control outputs
  always_comb begin
    state_s = state_r;
    row_s   = row_r;
    col_s   = col_r;
    addr_s  = addr_r;
    rd_s    = rd_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
`ifdef FMAP_STREAM_GAP_EN
    gap_s   = gap_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = READ;
          rd_s    = 1'b1;
          addr_s  = ADDR_BASE;
          row_s   = '0;
          col_s   = '0;
          busy_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (last_pix_s) begin
          state_s = LAST;
          rd_s    = 1'b0;
        end else begin
          addr_s = addr_r + ADDR_ONE;
          if (col_r == CNT_LAST) begin
            col_s = '0;
            row_s = row_r + CNT_ONE;
`ifdef FMAP_STREAM_GAP_EN
            if (ROW_GAP != 0) begin
              state_s = GAP;
              rd_s    = 1'b0;
              gap_s   = '0;
            end else begin
              state_s = READ;
            end
`endif
          end else begin
            col_s = col_r + CNT_ONE;
          end
        end
      end
`ifdef FMAP_STREAM_GAP_EN
      GAP: begin
        if (gap_r == GAP_LAST) begin
          state_s = READ;
          rd_s    = 1'b1;
        end else begin
          gap_s = gap_r + GAP_ONE;
        end
      end
`endif
      LAST: begin
        // done rises the cycle after stream_end; busy drops together with done
        if (done_r) begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end else if (end_r) begin
          done_s = 1'b1;
        end else begin
          state_s = LAST;
        end
      end
      default: begin
        state_s = IDLE;
        rd_s    = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Counters, read port and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_r  <= '0;
      col_r  <= '0;
      addr_r <= '0;
      rd_r   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
`ifdef FMAP_STREAM_GAP_EN
      gap_r  <= '0;
`endif
    end else if (ce) begin
      row_r  <= row_s;
      col_r  <= col_s;
      addr_r <= addr_s;
      rd_r   <= rd_s;
      busy_r <= busy_s;
      done_r <= done_s;
`ifdef FMAP_STREAM_GAP_EN
      gap_r  <= gap_s;
`endif
    end
  end

  // Stream valid/end track the read strobe one ce-cycle later; hold keeps the last pixel between valids
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r  <= 1'b0;
      end_r  <= 1'b0;
      hold_r <= '0;
    end else if (ce) begin
      vld_r <= rd_r;
      end_r <= rd_r && (state_r == READ) && last_pix_s;
      if (vld_r) begin
        hold_r <= bus.mem_dout;
      end
    end
  end

  // RAM data arrives in the valid cycle itself, so the pixel is passed straight through then
  assign bus.stream_dout = vld_r ? bus.mem_dout : hold_r;
  assign bus.stream_vld  = vld_r;
  assign bus.stream_end  = end_r;
  assign bus.mem_rd      = rd_r;
  assign bus.mem_addr    = addr_r;
  assign busy            = busy_r;
  assign done            = done_r;
endmodule

// File: doc/fmap_streamer.md
Name: fmap_streamer

Overview:
- Frame source for the conv stream: reads one feature map from a single-port feature RAM in raster order.
- Drives it as a pixel stream on the same vld/din/end protocol that padding, dconv, pconv and dwconv consume on input_vld/input_din.
- This is the transmit end of the layer stream interface. One pixel is one CHANNEL*N word holding all channels.
- Sits between the feature buffer and the first conv layer. Also replays intermediate maps between layers.

Parameters:
- N, 16, bit width of one channel sample
- CHANNEL, 3, channels packed per pixel word
- SIZE, 6, feature-map height and width (square)
- ADDR_W, 16, feature RAM address width
- BASE_ADDR, 0, RAM address of pixel (0,0)
- ROW_GAP, 2, idle cycles inserted between rows (used only with the optional feature)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- ce  input  1  clock enable; when 0 every register holds
- start  input  1  frame request, sampled only in IDLE with ce=1
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse after last pixel
- mem_rd  output  1  RAM read strobe
- mem_addr  output  ADDR_W  RAM read address
- mem_dout  input  CHANNEL*N  RAM read data, valid one ce-cycle after mem_rd
- stream_dout  output  CHANNEL*N  pixel data
- stream_vld  output  1  pixel valid
- stream_end  output  1  high with stream_vld on the last pixel of the frame

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low. All state is updated only when ce=1.
- Reset values: state=IDLE; busy, done, mem_rd, stream_vld, stream_end all 0; mem_addr=0; stream_dout=0; row and column counters 0.
- FSM states: IDLE, READ, GAP, LAST.
  - IDLE: start=1 → READ. Set mem_rd=1, mem_addr=BASE_ADDR, busy=1.
  - READ: one read issued per cycle. Address = BASE_ADDR + row*SIZE + col, row-major, col fastest, computed at ADDR_W width with wrap.
  - End of a row that is not the last row: → GAP if the macro is defined, otherwise stay in READ.
  - Read of pixel SIZE*SIZE-1 → LAST, with mem_rd=0 the next cycle.
  - GAP: mem_rd=0 for ROW_GAP cycles, then → READ at the next row start.
  - LAST: wait for the final pixel to leave, assert done for 1 cycle, clear busy, → IDLE.
- Data path:
  - stream_vld = mem_rd delayed by one ce-cycle.
  - stream_dout loads mem_dout only when the delayed read is valid. Otherwise it holds its previous value; it never goes to X or 0 between pixels.
- stream_end is 1 only on the cycle carrying pixel SIZE*SIZE-1.
- done is asserted the cycle after stream_end.
- Latency: start sampled at cycle t (ce=1) → mem_rd at t+1 → first stream_vld at t+2. Without gaps the SIZE*SIZE valids are contiguous.
- start while busy is ignored; no queueing. start on the done cycle is also ignored; IDLE is reached the cycle after done.
- ce=0 mid-frame: counters, FSM, mem_rd/mem_addr and all stream outputs freeze, and levels are held. A read in flight is replayed to memory by the held strobe. The RAM is ce-gated by the same ce.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values. No end or done pulse is emitted for the aborted frame.
- ROW_GAP=0 with the macro defined behaves exactly like the macro undefined.

Optional Feature:
- Macro FMAP_STREAM_GAP_EN.
- Defined: ROW_GAP idle cycles are inserted between consecutive rows, never after the last row. Frame time from first vld to end = SIZE*SIZE + (SIZE-1)*ROW_GAP cycles. This gives downstream line buffers slack.
- Undefined: the GAP state and its counter are not synthesized, ROW_GAP is ignored, and the stream is fully contiguous.

Test Plan:
- Defaults, BASE_ADDR=0x10, RAM word = address, macro off; pulse start → mem_addr 0x10..0x33; 36 contiguous stream_vld with stream_dout = 0x10..0x33; stream_end on the 36th; done the next cycle; busy high 38 cycles.
- Same setup, ce low 3 cycles every 5th cycle → identical 36-word data sequence. Outputs held during ce=0. Exactly one stream_end and one done.
- start re-pulsed at pixel 10 and on the done cycle → no second frame; exactly 36 valids total.
- rst_n low at pixel 20 → all outputs 0 asynchronously, before the next clk edge. A new start afterwards → a full 36-pixel frame from 0x10.
- Macro on, ROW_GAP=2 → rows of 6 valids separated by 2 idle cycles. First vld to end = 46 cycles. stream_dout holds the last pixel of the row during the gap.
- Macro on, ROW_GAP=0 → cycle-identical to the first scenario.
